btn_step_pulse: RTL and testbench

- Consumes the level from the push-button debouncer and turns it into single-cycle `step_pulse` strobes in the main `clk` domain.
- Strobes drive single-step of the multi-cycle CPU.
- A long press auto-repeats after a hold time, for fast stepping.
- Also provides a long-press level flag and a wrapping press counter for display.

---
 rtl/btn_step_pulse.sv | 119 +++++++++++
 tb/tb_btn_step_pulse.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_step_pulse.sv
// Converts a debounced button level into single-cycle step strobes, with
// auto-repeat on long press, a long-press level flag and a wrapping press counter.
module btn_step_pulse #(
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    input  logic             repeat_en,
    output logic             step_pulse,
    output logic             long_press,
    output logic [CNT_W-1:0] press_count
);

    // state    | meaning
    // IDLE     | button released, waiting for a synchronised rising edge
    // PRESSED  | button held, counting towards the first auto-repeat
    // REPEAT   | long press active, emitting a pulse every REPEAT_CYCLES
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_e;

    localparam logic [31:0] HOLD_TC   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] REPEAT_TC = 32'(REPEAT_CYCLES - 1);

    logic             s1_q, s2_q, s3_q;
    state_e           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic             step_q, step_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rise;
    logic held;

    assign rise = s2_q & ~s3_q;
    assign held = s2_q;

    // s3 clears on reset so a button still held afterwards reads as a new press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= ST_IDLE;
            timer_q <= 32'd0;
            step_q  <= 1'b0;
            long_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            long_q  <= long_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        long_d  = long_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    step_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = 32'd0;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                // release outranks a terminal count on the same cycle
                if (!held) begin
                    state_d = ST_IDLE;
                end else if (timer_q == HOLD_TC) begin
                    step_d  = repeat_en;
                    long_d  = 1'b1;
                    timer_d = 32'd0;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_REPEAT: begin
                if (!held) begin
                    long_d  = 1'b0;
                    timer_d = 32'd0;
                    state_d = ST_IDLE;
                end else if (timer_q == REPEAT_TC) begin
                    step_d  = repeat_en;
                    timer_d = 32'd0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                long_d  = 1'b0;
                timer_d = 32'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign step_pulse  = step_q;
    assign long_press  = long_q;
    assign press_count = cnt_q;

endmodule

// File: tb/tb_btn_step_pulse.sv
// Bench for btn_step_pulse: directed press scenarios plus random presses, checked
// every cycle against an event-timing model of press, hold and repeat intervals.
module tb_btn_step_pulse;

    localparam int HOLD = 10;
    localparam int REP  = 4;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_in = 1'b0;
    logic          repeat_en = 1'b1;
    logic          step_pulse;
    logic          long_press;
    logic [CW-1:0] press_count;

    btn_step_pulse #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .repeat_en  (repeat_en),
        .step_pulse (step_pulse),
        .long_press (long_press),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: button samples from the last three edges, newest first
    bit smp[3];
    bit m_press;
    bit m_long;
    bit m_pulse;
    int m_cnt;
    int press_edge;
    int edge_n = 0;
    int pulse_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit held;
        bit prev;
        int e;
        if (!rst_n) begin
            smp     = '{0, 0, 0};
            m_press = 0;
            m_long  = 0;
            m_pulse = 0;
            m_cnt   = 0;
        end else begin
            held    = smp[1];
            prev    = smp[2];
            m_pulse = 0;
            if (!m_press) begin
                if (held && !prev) begin
                    m_pulse    = 1;
                    m_cnt      = (m_cnt + 1) % (1 << CW);
                    m_press    = 1;
                    press_edge = edge_n;
                end
            end else if (!held) begin
                m_press = 0;
                m_long  = 0;
            end else begin
                e = edge_n - press_edge;
                if (e == HOLD) begin
                    m_long  = 1;
                    m_pulse = repeat_en;
                end else if (e > HOLD && ((e - HOLD) % REP) == 0) begin
                    m_pulse = repeat_en;
                end
            end
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = btn_in;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        chk("long_press", 32'(long_press), 32'(m_long));
        chk("press_count", 32'(press_count), 32'(m_cnt));
        if (step_pulse === 1'b1) pulse_total++;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        run(n);
        rst_n = 1'b1;
    endtask

    int p0;
    int hi_len;
    int lo_len;

    initial begin
        smp = '{0, 0, 0};
        m_press = 0; m_long = 0; m_pulse = 0; m_cnt = 0; press_edge = 0;

        do_reset(3);
        run(2);
        chk("reset_count", 32'(press_count), 32'd0);

        // short press: one pulse, no long press
        p0 = pulse_total;
        btn_in = 1'b1; run(3);
        btn_in = 1'b0; run(6);
        chk("t1_pulses", 32'(pulse_total - p0), 32'd1);
        chk("t1_count", 32'(press_count), 32'd1);

        // 30-cycle hold with repeat: t0, +10, +14, +18, +22, +26
        p0 = pulse_total;
        repeat_en = 1'b1;
        btn_in = 1'b1; run(30);
        btn_in = 1'b0; run(6);
        chk("t2_pulses", 32'(pulse_total - p0), 32'd6);

        // same with repeat disabled: only the press pulse
        p0 = pulse_total;
        repeat_en = 1'b0;
        btn_in = 1'b1; run(30);
        btn_in = 1'b0; run(6);
        chk("t3_pulses", 32'(pulse_total - p0), 32'd1);
        repeat_en = 1'b1;

        // 256 short presses wrap the counter back to zero
        do_reset(2);
        p0 = pulse_total;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1; run(3);
            btn_in = 1'b0; run(3);
        end
        run(3);
        chk("t4_pulses", 32'(pulse_total - p0), 32'd256);
        chk("t4_count", 32'(press_count), 32'd0);

        // reset during a long hold, button still held afterwards
        btn_in = 1'b1; run(14);
        do_reset(2);
        p0 = pulse_total;
        run(8);
        chk("t5_pulses", 32'(pulse_total - p0), 32'd1);
        chk("t5_count", 32'(press_count), 32'd1);
        btn_in = 1'b0; run(5);

        // release lands on the hold terminal count: release wins
        p0 = pulse_total;
        btn_in = 1'b1; run(10);
        btn_in = 1'b0; run(6);
        chk("t6_pulses", 32'(pulse_total - p0), 32'd1);
        chk("t6_long", 32'(long_press), 32'd0);

        // one cycle longer reaches the hold point
        p0 = pulse_total;
        btn_in = 1'b1; run(11);
        btn_in = 1'b0; run(6);
        chk("t6b_pulses", 32'(pulse_total - p0), 32'd2);

        // random presses, glitches, repeat_en toggling and occasional resets
        for (int k = 0; k < 120; k++) begin
            hi_len = $urandom_range(1, 40);
            lo_len = $urandom_range(1, 8);
            btn_in = 1'b1;
            for (int j = 0; j < hi_len; j++) begin
                if ($urandom_range(0, 7) == 0) repeat_en = ~repeat_en;
                cyc();
            end
            btn_in = 1'b0;
            run(lo_len);
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
        end
        btn_in = 1'b0;
        run(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
